fixed_bias_add_join: RTL



---
 rtl/fixed_bias_add_join_pkg.sv | 27 ++
 rtl/fixed_bias_skid_buffer.sv | 67 ++++++
 rtl/fixed_bias_add_join.sv | 99 +++++++++
 3 files changed

// File: rtl/fixed_bias_add_join_pkg.sv
// Shared helpers for the fixed-point bias-add join stage.
// Derivations of lane count, row depth, alignment shift and counter width.
package fixed_bias_add_join_pkg;

    // Values for the default configuration
    localparam int DEF_P          = 1;
    localparam int DEF_BIAS_DEPTH = 32;
    localparam int DEF_SHIFT      = 5;

    function automatic int lanes(input int par0, input int par1);
        return par0 * par1;
    endfunction

    function automatic int beats_per_row(input int size0, input int par0);
        return size0 / par0;
    endfunction

    function automatic int align_shift(input int data_frac, input int bias_frac);
        return data_frac - bias_frac;
    endfunction

    // One spare bit keeps BIAS_DEPTH=1 at a legal nonzero width
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fixed_bias_skid_buffer.sv
// Generic 2-entry valid/ready register slice (main + skid).
// Ready depends only on local state, so there is no comb path from out_ready.
module fixed_bias_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             push;
    logic             hold;

    assign in_ready  = ~skid_valid_q;
    assign push      = in_valid & in_ready;
    assign hold      = main_valid_q & ~out_ready;
    assign out_data  = main_q;
    assign out_valid = main_valid_q;

    // Next state: hold main while stalled, refill from skid first to keep order
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (hold) begin
            if (push) begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else begin
            main_valid_d = push;
            if (push) begin
                main_d = in_data;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/fixed_bias_add_join.sv
// Joins matmul output with its bias stream and adds them lane by lane.
// Bias is sign-extended and shifted to the data binary point; output is registered.
module fixed_bias_add_join
    import fixed_bias_add_join_pkg::*;
#(
    parameter int DATA_IN_PRECISION_0  = 32,
    parameter int DATA_IN_PRECISION_1  = 8,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = DATA_IN_PRECISION_0 + 1,
    parameter int TENSOR_SIZE_DIM_0    = 32,
    parameter int PARALLELISM_DIM_0    = 1,
    parameter int PARALLELISM_DIM_1    = 1,
    localparam int P          = lanes(PARALLELISM_DIM_0, PARALLELISM_DIM_1),
    localparam int BIAS_DEPTH = beats_per_row(TENSOR_SIZE_DIM_0, PARALLELISM_DIM_0),
    localparam int SHIFT      = align_shift(DATA_IN_PRECISION_1, BIAS_PRECISION_1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_IN_PRECISION_0-1:0]  data_in [P],
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic [BIAS_PRECISION_0-1:0]     bias_in [P],
    input  logic                            bias_in_valid,
    output logic                            bias_in_ready,
    output logic [DATA_OUT_PRECISION_0-1:0] data_out [P],
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_last
);

    localparam int DW = DATA_OUT_PRECISION_0;
    localparam int PW = P * DW + 1;
    localparam int CW = cnt_width(BIAS_DEPTH);

    if (BIAS_PRECISION_1 > DATA_IN_PRECISION_1) begin : g_bad_frac
        $error("bias fractional bits exceed data fractional bits");
    end
    if (BIAS_PRECISION_0 + SHIFT > DATA_IN_PRECISION_0) begin : g_bad_width
        $error("aligned bias wider than data input");
    end

    logic          can_accept;
    logic          buf_ready;
    logic          fire;
    logic          last_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    assign can_accept    = buf_ready & ~rst;
    assign data_in_ready = bias_in_valid & can_accept;
    assign bias_in_ready = data_in_valid & can_accept;
    assign fire          = data_in_valid & bias_in_valid & can_accept;
    assign last_in       = (cnt_q == CW'(BIAS_DEPTH - 1));

    for (genvar i = 0; i < P; i++) begin : g_lane
        logic signed [DW-1:0] d_ext;
        logic signed [DW-1:0] b_ext;
        assign d_ext = DW'($signed(data_in[i]));
        assign b_ext = DW'($signed(bias_in[i])) <<< SHIFT;
        assign in_payload[1 + i*DW +: DW] = d_ext + b_ext;
        assign data_out[i] = out_payload[1 + i*DW +: DW];
    end

    assign in_payload[0] = last_in;
    assign data_out_last = out_payload[0];

    // Beat position within the row, advanced only on a real transfer
    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = last_in ? '0 : cnt_q + CW'(1);
        end
    end

    // Beat counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    fixed_bias_skid_buffer #(
        .WIDTH(PW)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_payload),
        .in_valid (fire),
        .in_ready (buf_ready),
        .out_data (out_payload),
        .out_valid(data_out_valid),
        .out_ready(data_out_ready)
    );

endmodule
